btn_debounce: RTL

- Per-bit synchroniser and debouncer for raw push-button inputs (board KEYs, active-low, idle high).
- Sits directly upstream of the button PIO. Its btn_out drives the PIO in_port, so the PIO edge-capture/IRQ logic only sees one clean transition per physical press or release.
- Also emits registered one-cycle press, release and long-press strobes for fabric logic that does not go through the bus.

---
 rtl/btn_debounce.sv | 106 ++++++++++
 1 files changed

// File: rtl/btn_debounce.sv
// Per-bit two-flop synchroniser and debouncer for raw push-button pins, with
// registered one-cycle press, release and long-press strobes per channel.
module btn_debounce #(
  parameter int          WIDTH           = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter bit          RESET_LEVEL     = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] btn_in,
  output logic [WIDTH-1:0] btn_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] hold_pulse
);

  localparam int DW = $clog2(64'(DEBOUNCE_CYCLES) + 64'd1);
  localparam int HW = $clog2(64'(HOLD_CYCLES) + 64'd1);

  localparam logic [DW-1:0]    DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic             RELEASED  = RESET_LEVEL;
  localparam logic             PRESSED   = ~RESET_LEVEL;
  localparam logic [WIDTH-1:0] IDLE      = {WIDTH{RESET_LEVEL}};

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] press_q, press_d;
  logic [WIDTH-1:0] release_q, release_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [DW-1:0]    db_cnt_q   [WIDTH];
  logic [DW-1:0]    db_cnt_d   [WIDTH];
  logic [HW-1:0]    hold_cnt_q [WIDTH];
  logic [HW-1:0]    hold_cnt_d [WIDTH];

  always_comb begin
    sync1_d   = btn_in;
    sync2_d   = sync1_q;
    stable_d  = stable_q;
    press_d   = '0;
    release_d = '0;
    hold_d    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      db_cnt_d[i]   = '0;
      hold_cnt_d[i] = '0;

      // Any sample agreeing with the accepted level drops all accumulated credit.
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end

      press_d[i]   = (stable_d[i] != stable_q[i]) && (stable_d[i] == PRESSED);
      release_d[i] = (stable_d[i] != stable_q[i]) && (stable_d[i] == RELEASED);

      // The press cycle itself is count 0; the counter parks at its last value.
      if ((stable_q[i] == PRESSED) && (stable_d[i] == PRESSED)) begin
        if (hold_cnt_q[i] == HOLD_LAST) begin
          hold_cnt_d[i] = hold_cnt_q[i];
        end else begin
          hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
        end
      end

      hold_d[i] = (stable_d[i] == PRESSED) && (hold_cnt_d[i] == HOLD_LAST) &&
                  !((stable_q[i] == PRESSED) && (hold_cnt_q[i] == HOLD_LAST));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= IDLE;
      sync2_q   <= IDLE;
      stable_q  <= IDLE;
      press_q   <= '0;
      release_q <= '0;
      hold_q    <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        db_cnt_q[i]   <= '0;
        hold_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      hold_q    <= hold_d;
      for (int i = 0; i < WIDTH; i++) begin
        db_cnt_q[i]   <= db_cnt_d[i];
        hold_cnt_q[i] <= hold_cnt_d[i];
      end
    end
  end

  assign btn_out       = stable_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign hold_pulse    = hold_q;

endmodule
